// File: rtl/dispenser_pkg.sv
// Shared definitions for the soda machine actuator back end.
// - T-code constants shared with the coin-acceptance FSM
// - FSM state encoding of the dispenser
// - job descriptor {d, n5, n10} plus decode / sequencing helpers
package dispenser_pkg;

  localparam logic [1:0] T0  = 2'b00;  // no change
  localparam logic [1:0] T5  = 2'b01;  // one 5c coin
  localparam logic [1:0] T10 = 2'b10;  // one 10c coin
  localparam logic [1:0] T20 = 2'b11;  // two 10c coins

  typedef enum logic [2:0] {
    StIdle,
    StProd,
    StCoin5,
    StCoin10,
    StGap,
    StFault
  } state_e;

  typedef struct packed {
    logic       d;
    logic       n5;
    logic [1:0] n10;
  } job_t;

  function automatic job_t decode_job(input logic d1, input logic [1:0] t);
    job_t j;
    j.d  = d1;
    j.n5 = (t == T5);
    case (t)
      T10:     j.n10 = 2'd1;
      T20:     j.n10 = 2'd2;
      default: j.n10 = 2'd0;
    endcase
    return j;
  endfunction

  function automatic logic has_work(input job_t j);
    return j.d | j.n5 | (j.n10 != 2'd0);
  endfunction

  // First handshake of the remaining work; StIdle means nothing left.
  function automatic state_e first_state(input job_t j);
    if (j.d)                 return StProd;
    else if (j.n5)           return StCoin5;
    else if (j.n10 != 2'd0)  return StCoin10;
    else                     return StIdle;
  endfunction

endpackage

// File: rtl/handshake_timer.sv
// Timeout guard for one req/ack handshake.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   run       - req high and no ack this cycle; counter clears whenever low
//   expire    - this is the last allowed cycle without ack
module handshake_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned TMR_W       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam logic [TMR_W-1:0] LastCnt = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expire = run && (cnt_q == LastCnt);

endmodule

// File: rtl/dispensa_troco.sv
// Actuator back end: turns dispense/change codes into req/ack handshakes.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   D1, T                       - event code pair from the vending FSM (one cycle)
//   prod_req / prod_ack         - product gate handshake
//   coin5_req, coin10_req       - coin ejector requests, shared coin_ack
//   clr_fault                   - operator clear
//   busy, fault, ovf            - front panel status
module dispensa_troco
  import dispenser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned TMR_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       D1,
  input  logic [1:0] T,
  output logic       prod_req,
  input  logic       prod_ack,
  output logic       coin5_req,
  output logic       coin10_req,
  input  logic       coin_ack,
  input  logic       clr_fault,
  output logic       busy,
  output logic       fault,
  output logic       ovf
);

  state_e state_q, state_d;
  job_t   act_q, act_d;
  job_t   pend_q, pend_d;
  logic   pend_vld_q, pend_vld_d;
  logic   ovf_q, ovf_d;
  logic   prod_req_q, coin5_req_q, coin10_req_q;
  logic   prod_req_d, coin5_req_d, coin10_req_d;

  logic ev;
  job_t ev_job;
  logic ack_hit;
  logic tmo;
  logic queue_ev;  // event must go to the pending slot (or be dropped)

  assign ev     = D1 | (T != T0);
  assign ev_job = decode_job(D1, T);

  // An ack only counts while its own req is actually high.
  assign ack_hit = (prod_req_q & prod_ack) | ((coin5_req_q | coin10_req_q) & coin_ack);

  handshake_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   ((prod_req_q | coin5_req_q | coin10_req_q) & ~ack_hit),
    .expire(tmo)
  );

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q & ~clr_fault;
    queue_ev   = 1'b0;

    case (state_q)
      StIdle: begin
        if (ev) begin
          act_d   = ev_job;
          state_d = first_state(ev_job);
        end
      end
      StProd, StCoin5, StCoin10: begin
        queue_ev = ev;
        if (ack_hit) begin
          state_d = StGap;
          if (state_q == StProd)       act_d.d   = 1'b0;
          else if (state_q == StCoin5) act_d.n5  = 1'b0;
          else                         act_d.n10 = act_q.n10 - 2'd1;
        end else if (tmo) begin
          state_d = StFault;
        end
      end
      StGap: begin
        if (has_work(act_q)) begin
          state_d  = first_state(act_q);
          queue_ev = ev;
        end else if (pend_vld_q) begin
          // Completion: promote pending; a same-cycle event refills the slot.
          act_d   = pend_q;
          state_d = first_state(pend_q);
          if (ev) pend_d = ev_job;
          else    pend_vld_d = 1'b0;
        end else if (ev) begin
          act_d   = ev_job;
          state_d = first_state(ev_job);
        end else begin
          state_d = StIdle;
        end
      end
      StFault: begin
        if (clr_fault) state_d = StIdle;
        else if (ev)   ovf_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (queue_ev) begin
      if (!pend_vld_q) begin
        pend_d     = ev_job;
        pend_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (state_d == StFault) begin
      act_d      = '0;
      pend_vld_d = 1'b0;
    end

    // Leaving IDLE costs one cycle before the req rises; GAP pre-arms the
    // next req so the low time between handshakes is exactly one cycle.
    prod_req_d   = (state_d == StProd)   && (state_q != StIdle);
    coin5_req_d  = (state_d == StCoin5)  && (state_q != StIdle);
    coin10_req_d = (state_d == StCoin10) && (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      act_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      ovf_q        <= 1'b0;
      prod_req_q   <= 1'b0;
      coin5_req_q  <= 1'b0;
      coin10_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      ovf_q        <= ovf_d;
      prod_req_q   <= prod_req_d;
      coin5_req_q  <= coin5_req_d;
      coin10_req_q <= coin10_req_d;
    end
  end

  assign prod_req   = prod_req_q;
  assign coin5_req  = coin5_req_q;
  assign coin10_req = coin10_req_q;
  assign busy       = (state_q != StIdle) | pend_vld_q;
  assign fault      = (state_q == StFault);
  assign ovf        = ovf_q;

endmodule
